recv_request_matcher: RTL and testbench
=======================================

Name: recv_request_matcher

Overview:
- Receive-side requester for the eager-message store. Accepts posted receives (source index) from the Nios2 accelerator front end.
- Issues single-cycle reads to the store's read port and polls with backoff until a packet is present or the timeout expires.
- Returns the matched packet or a timeout status through a valid/ready response channel.
- Sits between the host request interface and the store's read port; the network owns the write port.

Parameters:
- PACKETIZER_WIDTH, 128, width of a stored packet and of the response data.
- ADDR_WIDTH, 2, source-index width; the store holds 2**ADDR_WIDTH slots.
- POLL_INTERVAL, 4, idle cycles between successive polls after a miss; minimum 1.
- TIMEOUT_WIDTH, 16, width of the per-request timeout count.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  receive request present.
- req_ready  out  1  matcher can accept a request.
- req_src  in  ADDR_WIDTH  source slot to match.
- req_timeout  in  TIMEOUT_WIDTH  cycle budget; 0 means wait forever.
- cam_re  out  1  store read enable; one-cycle pulse.
- cam_addr  out  ADDR_WIDTH  store read address.
- cam_q  in  PACKETIZER_WIDTH  store read data, registered one cycle after cam_re; all-zero means no data.
- net_we  in  1  network write to the store is active this cycle.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  PACKETIZER_WIDTH  matched packet; 0 on timeout.
- resp_status  out  2  00 OK, 01 TIMEOUT; 10 and 11 reserved.

Behaviour:
- Reset (async, immediate) sets: state IDLE, req_ready=1, cam_re=0, cam_addr=0, resp_valid=0, resp_data=0, resp_status=00, timers cleared. A reset mid-operation abandons the request with no response. A store read already issued is lost; it is not replayed.
- States: IDLE, ISSUE, LOOKUP, BACKOFF, RESP.
- IDLE: req_ready=1. On req_valid, latch req_src and req_timeout and go to ISSUE. req_ready=0 in every other state.
- ISSUE: if net_we=1, stall with cam_re=0. A read concurrent with a network write returns data without clearing the slot's valid tag, so that read is forbidden. Otherwise drive cam_re=1 with cam_addr=latched src for exactly one cycle, then go to LOOKUP.
- LOOKUP: sample cam_q. Non-zero means hit: register resp_data=cam_q and resp_status=OK, then go to RESP. Zero means miss: load the poll counter with POLL_INTERVAL-1 and go to BACKOFF.
- BACKOFF: the poll counter decrements each cycle. At 0, go to ISSUE. If the timeout expires first, register resp_data=0 and resp_status=TIMEOUT, then go to RESP.
- Timeout counter:
  - Loaded with req_timeout at accept and decremented every cycle outside IDLE and RESP; saturates at 0.
  - Expiry is checked only in BACKOFF, so a read already issued is always resolved first.
  - req_timeout=0 disables expiry.
- RESP: resp_valid=1, with data and status held stable until resp_ready. On the resp_valid && resp_ready cycle, go to IDLE.
- Best-case latency: accept at cycle 0, cam_re at 1, sample at 2, resp_valid at 3.
- A miss costs 2+POLL_INTERVAL cycles per retry.
- cam_addr holds its value between reads.

Optional Feature:
- Macro RECV_ANY_SOURCE_EN.
- Defined: adds input req_any (1 bit), latched at accept. When req_any=1, successive polls scan cam_addr round-robin 0..2**ADDR_WIDTH-1, starting at req_src and wrapping. A hit on any slot ends the request. resp_data carries the packet, so the consumer can identify the source. BACKOFF is applied only after a full scan with no hit.
- Undefined: the port is absent and only exact-source matching exists.

Decomposition:
- Package recv_matcher_pkg holds:
  - the state enum;
  - status encodings STATUS_OK=2'b00 and STATUS_TIMEOUT=2'b01;
  - the all-zero miss constant.
- One sub-module, recv_poll_timer, holds the poll countdown and the saturating timeout countdown. It exposes poll_done and timeout_expired.

Test Plan:
- Slot 2 preloaded with 128'hA5; request src=2, timeout=0 -> cam_re at cycle 1 with addr 2, resp_valid at cycle 3, data 128'hA5, status OK.
- Slot 1 empty, src=1, timeout=0; packet 128'h77 written at cycle 10 -> repeated polls every 6 cycles, first read after the write hits, response carries 128'h77.
- Slot 3 empty, timeout=20 -> TIMEOUT response with data 0, on the first BACKOFF cycle at or after the count reaches 0; no cam_re after expiry.
- net_we held high for 5 cycles starting at ISSUE -> cam_re withheld 5 cycles and issued on the sixth; the hit is still returned exactly once.
- Hit response with resp_ready low for 7 cycles -> resp_valid, data and status stable; req_ready stays 0; one transfer occurs on release.
- rst asserted asynchronously in BACKOFF -> all outputs return to reset values immediately; a new request after release is accepted in IDLE.

Source files
------------

// File: rtl/recv_matcher_pkg.sv
// Shared types and constants for the receive-request matcher.
package recv_matcher_pkg;

  // Matcher control states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOOKUP,
    ST_BACKOFF,
    ST_RESP
  } state_t;

  // Response status encodings (2'b10 and 2'b11 reserved)
  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;

  // An empty store slot reads back as all zeros; wide enough for any packet width
  localparam int unsigned      MISS_MAX_W = 1024;
  localparam logic [MISS_MAX_W-1:0] MISS_PKT = '0;

endpackage

// File: rtl/recv_poll_timer.sv
// Poll-interval countdown and saturating per-request timeout countdown.
module recv_poll_timer #(
  parameter int unsigned POLL_INTERVAL = 4,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tmo_load,
  input  logic [TIMEOUT_WIDTH-1:0] tmo_value,
  input  logic                     tmo_run,
  input  logic                     poll_load,
  input  logic                     poll_run,
  output logic                     poll_done,
  output logic                     timeout_expired
);

  localparam int unsigned           POLL_W      = $clog2(POLL_INTERVAL + 1);
  localparam logic [POLL_W-1:0]     POLL_RELOAD = POLL_W'(POLL_INTERVAL - 1);

  logic [POLL_W-1:0]        poll_cnt;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic                     tmo_en;

  // Poll countdown: reloaded after a miss, runs down during backoff
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_load) begin
      poll_cnt <= POLL_RELOAD;
    end else if (poll_run && (poll_cnt != '0)) begin
      poll_cnt <= poll_cnt - 1'b1;
    end
  end

  // Timeout countdown: a zero budget at accept disables expiry for the request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_en  <= 1'b0;
    end else if (tmo_load) begin
      tmo_cnt <= tmo_value;
      tmo_en  <= (tmo_value != '0);
    end else if (tmo_run && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign poll_done       = (poll_cnt == '0);
  assign timeout_expired = tmo_en && (tmo_cnt == '0);

endmodule

// File: rtl/recv_request_matcher.sv
// Receive-side requester: polls the eager-message store for a posted receive,
// backing off between misses, and returns the packet or a timeout status.
// Optional feature macro RECV_ANY_SOURCE_EN adds req_any for round-robin
// any-source matching; without it only exact-source matching exists.
module recv_request_matcher
  import recv_matcher_pkg::*;
#(
  parameter int unsigned PACKETIZER_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH       = 2,
  parameter int unsigned POLL_INTERVAL    = 4,
  parameter int unsigned TIMEOUT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-1:0]       req_src,
  input  logic [TIMEOUT_WIDTH-1:0]    req_timeout,
`ifdef RECV_ANY_SOURCE_EN
  input  logic                        req_any,
`endif
  output logic                        cam_re,
  output logic [ADDR_WIDTH-1:0]       cam_addr,
  input  logic [PACKETIZER_WIDTH-1:0] cam_q,
  input  logic                        net_we,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [PACKETIZER_WIDTH-1:0] resp_data,
  output logic [1:0]                  resp_status
);

  state_t state;
  logic   hit;
  logic   scan_wrap;
  logic   tmo_load;
  logic   tmo_run;
  logic   poll_load;
  logic   poll_run;
  logic   poll_done;
  logic   timeout_expired;

  assign hit = (cam_q != PACKETIZER_WIDTH'(MISS_PKT));

`ifdef RECV_ANY_SOURCE_EN
  logic                  any_q;
  logic [ADDR_WIDTH-1:0] scan_cnt;

  // Backoff only after every slot has been tried once in any-source mode
  assign scan_wrap = !any_q || (scan_cnt == '1);
`else
  assign scan_wrap = 1'b1;
`endif

  // A read may not coincide with a network write, since it would not clear the slot tag
  assign cam_re = (state == ST_ISSUE) && !net_we;

  // Timer controls derived from the current state
  assign tmo_load  = (state == ST_IDLE) && req_valid;
  assign tmo_run   = (state inside {ST_ISSUE, ST_LOOKUP, ST_BACKOFF});
  assign poll_load = (state == ST_LOOKUP) && !hit && scan_wrap;
  assign poll_run  = (state == ST_BACKOFF);

  recv_poll_timer #(
    .POLL_INTERVAL (POLL_INTERVAL),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk             (clk),
    .rst             (rst),
    .tmo_load        (tmo_load),
    .tmo_value       (req_timeout),
    .tmo_run         (tmo_run),
    .poll_load       (poll_load),
    .poll_run        (poll_run),
    .poll_done       (poll_done),
    .timeout_expired (timeout_expired)
  );

  // Request/poll/response sequencing with registered handshake and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b1;
      cam_addr    <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_status <= STATUS_OK;
`ifdef RECV_ANY_SOURCE_EN
      any_q       <= 1'b0;
      scan_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cam_addr  <= req_src;
            req_ready <= 1'b0;
            state     <= ST_ISSUE;
`ifdef RECV_ANY_SOURCE_EN
            any_q     <= req_any;
            scan_cnt  <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (!net_we) begin
            state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (hit) begin
            resp_data   <= cam_q;
            resp_status <= STATUS_OK;
            resp_valid  <= 1'b1;
            state       <= ST_RESP;
          end else begin
`ifdef RECV_ANY_SOURCE_EN
            if (any_q) begin
              cam_addr <= cam_addr + 1'b1;
              scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            end
`endif
            state <= scan_wrap ? ST_BACKOFF : ST_ISSUE;
          end
        end
        ST_BACKOFF: begin
          if (timeout_expired) begin
            resp_data   <= PACKETIZER_WIDTH'(MISS_PKT);
            resp_status <= STATUS_TIMEOUT;
            resp_valid  <= 1'b1;
            state       <= ST_RESP;
          end else if (poll_done) begin
            state <= ST_ISSUE;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recv_request_matcher.sv
// Bench for recv_request_matcher: directed plan cases plus randomized requests
// checked against a timeline model of the polling rules.
module tb_recv_request_matcher;

  localparam int unsigned PW   = 128;
  localparam int unsigned AW   = 2;
  localparam int unsigned PI   = 4;
  localparam int unsigned TW   = 16;
  localparam int          MAXC = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_src;
  logic [TW-1:0] req_timeout;
  logic          cam_re;
  logic [AW-1:0] cam_addr;
  logic [PW-1:0] cam_q;
  logic          net_we;
  logic          resp_valid;
  logic          resp_ready;
  logic [PW-1:0] resp_data;
  logic [1:0]    resp_status;

  // Store model signals
  logic [PW-1:0] mem [4];
  logic          mem_clr;
  logic [AW-1:0] pre_addr;
  logic [PW-1:0] pre_data;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;

  int passes = 0;
  int total  = 0;

  bit nw     [MAXC];
  bit exp_re [MAXC];

  always #5 clk = ~clk;

  recv_request_matcher dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src     (req_src),
    .req_timeout (req_timeout),
`ifdef RECV_ANY_SOURCE_EN
    .req_any     (1'b0),
`endif
    .cam_re      (cam_re),
    .cam_addr    (cam_addr),
    .cam_q       (cam_q),
    .net_we      (net_we),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_status (resp_status)
  );

  // Eager-message store: registered read that consumes the slot, network write port
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      mem[pre_addr] <= pre_data;
      cam_q <= '0;
    end else begin
      if (cam_re) begin
        cam_q <= mem[cam_addr];
        mem[cam_addr] <= '0;
      end
      if (net_we) mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One request: build the net_we schedule, predict the timeline, then run and compare.
  task automatic run_trial(input int src, input logic [PW-1:0] pre, input int tmo,
                           input int wc, input logic [PW-1:0] wd,
                           input int nw_start, input int nw_len,
                           input int noise_pct, input int hold);
    int t, r, b, rt, exp_r;
    logic [PW-1:0] exp_data;
    logic [1:0]    exp_stat;
    logic [AW-1:0] s;
    s = AW'(src);
    for (int k = 0; k < MAXC; k++) begin
      nw[k]     = (k >= 1) && ($urandom_range(0, 99) < noise_pct);
      exp_re[k] = 1'b0;
    end
    for (int k = nw_start; k < nw_start + nw_len; k++) nw[k] = 1'b1;
    if (wc >= 0) nw[wc] = 1'b1;

    // Timeline model: reads happen at the first write-free issue cycle; a miss costs
    // two cycles plus the poll interval; expiry is only seen during backoff cycles.
    t = 1;
    exp_r = -1;
    exp_data = '0;
    exp_stat = 2'b00;
    while (exp_r < 0) begin
      while (nw[t] && t < MAXC - 1) t++;
      if (t >= MAXC - 8) begin
        $display("FAIL model_bound observed=%0d expected=<%0d", t, MAXC - 8);
        $fatal(1);
      end
      r = t;
      exp_re[r] = 1'b1;
      if (pre != '0 || (wc >= 0 && wc < r)) begin
        exp_r    = r + 2;
        exp_data = (pre != '0) ? pre : wd;
        exp_stat = 2'b00;
      end else begin
        b = r + 2;
        if (tmo != 0 && b + int'(PI) - 1 >= tmo + 1) begin
          rt       = (b > tmo + 1) ? b : tmo + 1;
          exp_r    = rt + 1;
          exp_data = '0;
          exp_stat = 2'b01;
        end else begin
          t = b + int'(PI);
        end
      end
    end

    // Clear and preload the store while the matcher sits idle
    mem_clr  = 1'b1;
    pre_addr = s;
    pre_data = pre;
    req_valid = 1'b0;
    net_we = 1'b0;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    mem_clr = 1'b0;

    for (int k = 0; k <= exp_r + hold + 1; k++) begin
      req_valid   = (k == 0);
      req_src     = s;
      req_timeout = TW'(tmo);
      net_we      = (k == exp_r + hold + 1) ? 1'b0 : nw[k];
      wr_addr     = (k == wc) ? s : (s ^ AW'(1));
      wr_data     = (k == wc) ? wd : '0;
      resp_ready  = (k == exp_r + hold);
      #1;
      if (k == 0) check("req_ready_idle", PW'(req_ready), PW'(1'b1));
      if (k < exp_r) begin
        check("resp_valid_early", PW'(resp_valid), PW'(1'b0));
        check("cam_re_timing", PW'(cam_re), PW'(exp_re[k]));
        if (exp_re[k]) check("cam_addr", PW'(cam_addr), PW'(s));
      end else if (k <= exp_r + hold) begin
        check("resp_valid", PW'(resp_valid), PW'(1'b1));
        check("resp_data", resp_data, exp_data);
        check("resp_status", PW'(resp_status), PW'(exp_stat));
        check("req_ready_busy", PW'(req_ready), PW'(1'b0));
        check("cam_re_in_resp", PW'(cam_re), PW'(1'b0));
      end else begin
        check("resp_valid_after", PW'(resp_valid), PW'(1'b0));
        check("req_ready_after", PW'(req_ready), PW'(1'b1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, PW'(req_ready), PW'(1'b1));
    check({tag, "_cam_re"}, PW'(cam_re), PW'(1'b0));
    check({tag, "_cam_addr"}, PW'(cam_addr), PW'(0));
    check({tag, "_resp_valid"}, PW'(resp_valid), PW'(1'b0));
    check({tag, "_resp_data"}, resp_data, PW'(0));
    check({tag, "_resp_status"}, PW'(resp_status), PW'(0));
  endtask

  initial begin
    int src, tmo, wc, hold;
    logic [PW-1:0] pre, wd;
    rst = 1'b1;
    req_valid = 1'b0;
    req_src = '0;
    req_timeout = '0;
    net_we = 1'b0;
    resp_ready = 1'b0;
    mem_clr = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Preloaded hit, best-case latency
    run_trial(2, PW'(128'hA5), 0, -1, '0, 0, 0, 0, 0);
    // Empty slot, packet arrives at cycle 10, infinite wait
    run_trial(1, '0, 0, 10, PW'(128'h77), 0, 0, 0, 0);
    // Empty slot, timeout after 20 cycles
    run_trial(3, '0, 20, -1, '0, 0, 0, 0, 0);
    // Network write held for 5 cycles from ISSUE
    run_trial(0, PW'(128'h1234), 0, -1, '0, 1, 5, 0, 0);
    // Response back-pressured for 7 cycles
    run_trial(2, PW'(128'hBEEF), 0, -1, '0, 0, 0, 0, 7);

    // Asynchronous reset while in backoff abandons the request
    mem_clr = 1'b1;
    pre_addr = AW'(3);
    pre_data = '0;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    req_valid = 1'b1;
    req_src = AW'(3);
    req_timeout = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_trial(1, PW'(128'h42), 0, -1, '0, 0, 0, 0, 0);

    // Randomized requests
    for (int n = 0; n < 24; n++) begin
      src  = $urandom_range(0, 3);
      hold = $urandom_range(0, 3);
      pre  = '0;
      wd   = {$urandom, $urandom, $urandom, $urandom} | PW'(1);
      wc   = -1;
      tmo  = 0;
      case ($urandom_range(0, 2))
        0: pre = {$urandom, $urandom, $urandom, $urandom} | PW'(1);
        1: begin
          wc  = $urandom_range(1, 50);
          tmo = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 60);
        end
        default: tmo = $urandom_range(1, 40);
      endcase
      run_trial(src, pre, tmo, wc, wd, 0, 0, 15, hold);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
